// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and defaults for the pipeline stall/flush sequencer
package pipe_ctrl_pkg;

   localparam int PIPE_REG_AW       = 4;
   localparam int PIPE_DRAIN_CYCLES = 3;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_DRAIN    = 2'd2,
      ST_HALTED   = 2'd3
   } ctrl_state_t;

   typedef struct packed {
      logic pc_we;
      logic fd_en;
      logic fd_flush;
      logic dx_en;
      logic dx_flush;
      logic xm_en;
      logic mw_en;
   } pipe_ctl_t;

   // Free-running pipeline: every bank advances, nothing flushed.
   function automatic pipe_ctl_t ctl_run();
      pipe_ctl_t c;
      c = '0;
      c.pc_we = 1'b1;
      c.fd_en = 1'b1;
      c.dx_en = 1'b1;
      c.xm_en = 1'b1;
      c.mw_en = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - decode/execute fields, cache handshakes and bank controls
interface pipe_hazard_ctrl_if #(parameter int REG_AW = 4);

   logic [REG_AW-1:0] d_rs;
   logic [REG_AW-1:0] d_rt;
   logic              d_uses_rs;
   logic              d_uses_rt;
   logic              d_branch_taken;
   logic              d_halt;
   logic              x_memread;
   logic              x_regwrite;
   logic [REG_AW-1:0] x_rd;
   logic              if_miss;
   logic              mem_miss;
   logic              mem_fill_done;
   logic              pc_we;
   logic              fd_en;
   logic              fd_flush;
   logic              dx_en;
   logic              dx_flush;
   logic              xm_en;
   logic              mw_en;
   logic              halt_done;

   modport master (
      output d_rs, d_rt, d_uses_rs, d_uses_rt, d_branch_taken, d_halt,
             x_memread, x_regwrite, x_rd, if_miss, mem_miss, mem_fill_done,
      input  pc_we, fd_en, fd_flush, dx_en, dx_flush, xm_en, mw_en, halt_done
   );

   modport slave (
      input  d_rs, d_rt, d_uses_rs, d_uses_rt, d_branch_taken, d_halt,
             x_memread, x_regwrite, x_rd, if_miss, mem_miss, mem_fill_done,
      output pc_we, fd_en, fd_flush, dx_en, dx_flush, xm_en, mw_en, halt_done
   );

endinterface

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use compare between X destination and D sources
module hazard_detect #(
   parameter int REG_AW = 4
) (
   input  logic              x_memread,
   input  logic              x_regwrite,
   input  logic [REG_AW-1:0] x_rd,
   input  logic [REG_AW-1:0] d_rs,
   input  logic [REG_AW-1:0] d_rt,
   input  logic              d_uses_rs,
   input  logic              d_uses_rt,
   output logic              stall
);

   logic rs_hit;
   logic rt_hit;

   assign rs_hit = d_uses_rs && (d_rs == x_rd);
   assign rt_hit = d_uses_rt && (d_rt == x_rd);

   // r0 is hardwired zero, so a load targeting it never produces a value to wait on.
   assign stall = x_memread && x_regwrite && (x_rd != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline; PIPE_STALL_CNT_EN adds stall_cycles
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW       = PIPE_REG_AW,
   parameter int DRAIN_CYCLES = PIPE_DRAIN_CYCLES
) (
   input  logic              clk,
   input  logic              rst,
   pipe_hazard_ctrl_if.slave bus
`ifdef PIPE_STALL_CNT_EN
   ,
   output logic [15:0]       stall_cycles
`endif
);

   localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_CYCLES - 1);

   ctrl_state_t   state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          frz, frz_nxt;
   pipe_ctl_t     ctl;
   logic          halt_done_c;
   logic          hz;

   hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
      .x_memread (bus.x_memread),
      .x_regwrite(bus.x_regwrite),
      .x_rd      (bus.x_rd),
      .d_rs      (bus.d_rs),
      .d_rt      (bus.d_rt),
      .d_uses_rs (bus.d_uses_rs),
      .d_uses_rt (bus.d_uses_rt),
      .stall     (hz)
   );

   always_comb begin
      ctl         = '0;
      halt_done_c = 1'b0;
      state_nxt   = state;
      cnt_nxt     = cnt;
      frz_nxt     = frz;
      if (!rst) begin
         case (state)
            ST_RUN: begin
               ctl = ctl_run();
               if (bus.mem_miss) begin
                  ctl       = '0;
                  state_nxt = ST_MEM_WAIT;
               end else if (hz) begin
                  ctl.pc_we    = 1'b0;
                  ctl.fd_en    = 1'b0;
                  ctl.dx_flush = 1'b1;
               end else if (bus.if_miss) begin
                  // A taken branch still redirects the PC while fetch is missing.
                  ctl.pc_we    = bus.d_branch_taken;
                  ctl.fd_flush = 1'b1;
               end else if (bus.d_branch_taken) begin
                  ctl.fd_flush = 1'b1;
               end else if (bus.d_halt) begin
                  ctl.pc_we    = 1'b0;
                  ctl.fd_flush = 1'b1;
                  state_nxt    = ST_DRAIN;
                  cnt_nxt      = '0;
                  frz_nxt      = 1'b0;
               end
            end
            ST_MEM_WAIT: begin
               if (bus.mem_fill_done && !bus.mem_miss) begin
                  state_nxt = ST_RUN;
               end
            end
            ST_DRAIN: begin
               if (bus.mem_miss) begin
                  frz_nxt = 1'b1;
               end else if (frz) begin
                  frz_nxt = !bus.mem_fill_done;
               end else begin
                  ctl          = ctl_run();
                  ctl.pc_we    = 1'b0;
                  ctl.fd_flush = 1'b1;
                  ctl.dx_flush = 1'b1;
                  cnt_nxt      = cnt + 1'b1;
                  if (cnt == CNT_LAST) begin
                     state_nxt = ST_HALTED;
                  end
               end
            end
            default: begin
               halt_done_c = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_RUN;
         cnt   <= '0;
         frz   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         frz   <= frz_nxt;
      end
   end

   assign bus.pc_we     = ctl.pc_we;
   assign bus.fd_en     = ctl.fd_en;
   assign bus.fd_flush  = ctl.fd_flush;
   assign bus.dx_en     = ctl.dx_en;
   assign bus.dx_flush  = ctl.dx_flush;
   assign bus.xm_en     = ctl.xm_en;
   assign bus.mw_en     = ctl.mw_en;
   assign bus.halt_done = halt_done_c;

`ifdef PIPE_STALL_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles <= '0;
      end else if (!ctl.pc_we && (state == ST_RUN || state == ST_MEM_WAIT)
                   && stall_cycles != 16'hFFFF) begin
         stall_cycles <= stall_cycles + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized and directed checks of pipe_hazard_ctrl against a behavioural model
module tb_pipe_hazard_ctrl;

   localparam int DC = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;

   pipe_hazard_ctrl_if #(.REG_AW(4)) bus ();
`ifdef PIPE_STALL_CNT_EN
   logic [15:0] stall_cycles;
`endif

   pipe_hazard_ctrl #(.REG_AW(4), .DRAIN_CYCLES(DC)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
`ifdef PIPE_STALL_CNT_EN
      ,
      .stall_cycles(stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   // Model: 0 running, 1 waiting on D-cache fill, 2 draining, 3 halted.
   int m_mode    = 0;
   int m_drained = 0;
   int m_frozen  = 0;
   int m_stalls  = 0;

   function automatic bit load_use();
      return bus.x_memread && bus.x_regwrite && (bus.x_rd != 0) &&
             ((bus.d_uses_rs && bus.d_rs == bus.x_rd) ||
              (bus.d_uses_rt && bus.d_rt == bus.x_rd));
   endfunction

   // Vector order: pc_we fd_en fd_flush dx_en dx_flush xm_en mw_en halt_done
   function automatic logic [7:0] model_out();
      bit pc, fe, ff, de, df, xe, me, hd;
      {pc, fe, ff, de, df, xe, me, hd} = 8'b0;
      if (rst) return 8'b0;
      if (m_mode == 0) begin
         if (!bus.mem_miss) begin
            {pc, fe, de, xe, me} = 5'b11111;
            if (load_use()) begin
               pc = 0; fe = 0; df = 1;
            end else if (bus.if_miss) begin
               pc = bus.d_branch_taken; ff = 1;
            end else if (bus.d_branch_taken) begin
               ff = 1;
            end else if (bus.d_halt) begin
               pc = 0; ff = 1;
            end
         end
      end else if (m_mode == 2) begin
         if (!bus.mem_miss && m_frozen == 0) begin
            fe = 1; ff = 1; de = 1; df = 1; xe = 1; me = 1;
         end
      end else if (m_mode == 3) begin
         hd = 1;
      end
      return {pc, fe, ff, de, df, xe, me, hd};
   endfunction

   always @(posedge clk or posedge rst) begin
      logic [7:0] o;
      if (rst) begin
         m_mode <= 0; m_drained <= 0; m_frozen <= 0; m_stalls <= 0;
      end else begin
         o = model_out();
         if (!o[7] && m_mode < 2 && m_stalls < 65535) m_stalls <= m_stalls + 1;
         case (m_mode)
            0: begin
               if (bus.mem_miss) m_mode <= 1;
               else if (!load_use() && !bus.if_miss && !bus.d_branch_taken && bus.d_halt) begin
                  m_mode <= 2; m_drained <= 0; m_frozen <= 0;
               end
            end
            1: if (bus.mem_fill_done && !bus.mem_miss) m_mode <= 0;
            2: begin
               if (bus.mem_miss) m_frozen <= 1;
               else if (m_frozen != 0) begin
                  if (bus.mem_fill_done) m_frozen <= 0;
               end else begin
                  m_drained <= m_drained + 1;
                  if (m_drained + 1 == DC) m_mode <= 3;
               end
            end
            default: ;
         endcase
      end
   end

   function automatic logic [7:0] dut_vec();
      return {bus.pc_we, bus.fd_en, bus.fd_flush, bus.dx_en, bus.dx_flush,
              bus.xm_en, bus.mw_en, bus.halt_done};
   endfunction

   always @(negedge clk) begin
      logic [7:0] e, g;
      e = model_out();
      g = dut_vec();
      n_checks++;
      if (g !== e) $display("FAIL ctl_vs_model t=%0t got=%b expected=%b", $time, g, e);
      else n_pass++;
`ifdef PIPE_STALL_CNT_EN
      n_checks++;
      if (stall_cycles !== 16'(m_stalls))
         $display("FAIL stall_vs_model t=%0t got=%0d expected=%0d", $time, stall_cycles, m_stalls);
      else n_pass++;
`endif
   end

   task automatic lit(input string name, input logic [7:0] e);
      logic [7:0] g;
      g = dut_vec();
      n_checks++;
      if (g !== e) $display("FAIL %s got=%b expected=%b", name, g, e);
      else n_pass++;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.d_rs = 0; bus.d_rt = 0; bus.d_uses_rs = 0; bus.d_uses_rt = 0;
      bus.d_branch_taken = 0; bus.d_halt = 0; bus.x_memread = 0;
      bus.x_regwrite = 0; bus.x_rd = 0; bus.if_miss = 0;
      bus.mem_miss = 0; bus.mem_fill_done = 0;
   endtask

   task automatic set_load_use(input int rd);
      bus.x_memread = 1; bus.x_regwrite = 1; bus.x_rd = 4'(rd);
      bus.d_rs = 3; bus.d_uses_rs = 1;
   endtask

   task automatic do_reset();
      rst = 1; cyc(); cyc(); rst = 0; cyc();
   endtask

   initial begin
      idle();
      rst = 1;
      cyc();
      @(negedge clk); lit("reset_zero", 8'b00000000);
      cyc(); rst = 0;
      @(negedge clk); lit("run_default", 8'b11010110);
      cyc();

`ifdef PIPE_STALL_CNT_EN
      bus.if_miss = 1;
      repeat (4) cyc();
      idle(); set_load_use(3); cyc();
      idle(); @(negedge clk);
      n_checks++;
      if (stall_cycles !== 16'd5) $display("FAIL stall_cnt got=%0d expected=5", stall_cycles);
      else n_pass++;
      cyc();
`endif

      set_load_use(3);
      @(negedge clk); lit("load_use", 8'b00011110);
      cyc(); idle();
      @(negedge clk); lit("load_use_after", 8'b11010110);
      cyc();
      set_load_use(0);
      @(negedge clk); lit("load_use_r0", 8'b11010110);
      cyc(); idle();

      bus.d_branch_taken = 1;
      @(negedge clk); lit("branch", 8'b11110110);
      cyc(); idle();
      @(negedge clk); lit("branch_after", 8'b11010110);
      cyc();
      bus.d_branch_taken = 1; bus.if_miss = 1;
      @(negedge clk); lit("branch_if_miss", 8'b11110110);
      cyc(); idle();
      bus.if_miss = 1;
      @(negedge clk); lit("if_miss", 8'b01110110);
      cyc(); idle();

      bus.mem_miss = 1;
      @(negedge clk); lit("dmiss_0", 8'b00000000);
      cyc(); bus.mem_miss = 0;
      for (int i = 1; i < 6; i++) begin
         if (i == 5) bus.mem_fill_done = 1;
         @(negedge clk); lit($sformatf("dmiss_%0d", i), 8'b00000000);
         cyc();
      end
      idle();
      @(negedge clk); lit("dmiss_resume", 8'b11010110);
      cyc();
      set_load_use(3); bus.mem_miss = 1;
      @(negedge clk); lit("dmiss_over_hazard", 8'b00000000);
      cyc(); idle(); bus.mem_fill_done = 1;
      cyc(); idle();
      @(negedge clk); lit("dmiss2_resume", 8'b11010110);

      // Reset while waiting on a fill: outputs drop without waiting for a clock.
      bus.mem_miss = 1; cyc(); idle(); cyc();
      rst = 1; #1;
      lit("async_rst_memwait", 8'b00000000);
      cyc(); rst = 0;
      @(negedge clk); lit("after_rst_memwait", 8'b11010110);
      cyc();

      bus.d_halt = 1;
      @(negedge clk); lit("halt_issue", 8'b01110110);
      cyc(); idle();
      @(negedge clk); lit("drain_1", 8'b01111110);
      cyc(); bus.mem_miss = 1;
      @(negedge clk); lit("drain_miss", 8'b00000000);
      cyc(); idle(); cyc(); cyc(); bus.mem_fill_done = 1;
      @(negedge clk); lit("drain_fill", 8'b00000000);
      cyc(); idle();
      @(negedge clk); lit("drain_2", 8'b01111110);
      cyc();
      @(negedge clk); lit("drain_3", 8'b01111110);
      cyc();
      @(negedge clk); lit("halted", 8'b00000001);
      cyc();
      @(negedge clk); lit("halted_hold", 8'b00000001);
      rst = 1; #1;
      lit("async_rst_halted", 8'b00000000);
      cyc(); rst = 0;
      @(negedge clk); lit("after_rst_halted", 8'b11010110);
      cyc();

      for (int n = 0; n < 3000; n++) begin
         if (m_mode == 3 ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 299) == 0)) begin
            rst = 1; idle(); cyc(); rst = 0;
         end else begin
            bus.d_rs = 4'($urandom_range(0, 3));
            bus.d_rt = 4'($urandom_range(0, 3));
            bus.x_rd = 4'($urandom_range(0, 3));
            bus.d_uses_rs = 1'($urandom_range(0, 1));
            bus.d_uses_rt = 1'($urandom_range(0, 1));
            bus.x_memread = ($urandom_range(0, 2) == 0);
            bus.x_regwrite = ($urandom_range(0, 2) != 0);
            bus.d_branch_taken = ($urandom_range(0, 7) == 0);
            bus.d_halt = ($urandom_range(0, 31) == 0);
            bus.if_miss = ($urandom_range(0, 5) == 0);
            bus.mem_miss = ($urandom_range(0, 11) == 0);
            bus.mem_fill_done = ($urandom_range(0, 3) == 0);
            cyc();
         end
      end

      idle();
      cyc();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 16-bit 5-stage pipeline.
- Drives the enable and flush inputs of the F/D, D/X, X/M and M/W pipeline-register banks, and the PC write enable.
- Resolves load-use hazards, decode-resolved taken branches, I-cache and D-cache miss stalls, and HLT drain.
- Sits beside the decode stage; consumes decode and execute fields and the cache miss handshakes.

Parameters:
REG_AW, 4, register-file address width
DRAIN_CYCLES, 3, cycles for HLT to travel from D to W before halt_done

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  reset; asynchronous and active-high
d_rs  in  REG_AW  decode source register 1
d_rt  in  REG_AW  decode source register 2
d_uses_rs  in  1  decode instruction reads d_rs
d_uses_rt  in  1  decode instruction reads d_rt
d_branch_taken  in  1  branch in D resolved taken
d_halt  in  1  HLT instruction in D
x_memread  in  1  X-stage instruction is a load
x_regwrite  in  1  X-stage instruction writes the register file
x_rd  in  REG_AW  X-stage destination register
if_miss  in  1  I-cache miss; level signal, held until the fill completes
mem_miss  in  1  D-cache miss request
mem_fill_done  in  1  one-cycle pulse: D-cache fill complete
pc_we  out  1  PC write enable
fd_en  out  1  F/D register enable
fd_flush  out  1  F/D loads a NOP
dx_en  out  1  D/X register enable
dx_flush  out  1  D/X loads a bubble
xm_en  out  1  X/M register enable
mw_en  out  1  M/W register enable
halt_done  out  1  pipeline drained after HLT

Behaviour:
- States: RUN, MEM_WAIT, DRAIN, HALTED.
- State and drain counter use an asynchronous reset. Outputs are decoded combinationally from state and inputs.
- While rst is high:
  - state=RUN and counter=0.
  - All outputs are 0: enables, flushes and halt_done.
- Reset has priority in every state, including mid-MEM_WAIT and mid-DRAIN.
- RUN default: pc_we, fd_en, dx_en, xm_en, mw_en = 1; flushes = 0.
- Priority within RUN, highest first:
  1. mem_miss=1: freeze. All five enables are 0 in that same cycle. Next state MEM_WAIT.
  2. Load-use hazard: x_memread & x_regwrite & (x_rd!=0) & ((d_uses_rs & d_rs==x_rd) | (d_uses_rt & d_rt==x_rd)). Then pc_we=0, fd_en=0, dx_flush=1. Lasts exactly one cycle because the load advances.
  3. if_miss=1: pc_we=0, fd_flush=1; downstream stages keep running. A taken branch in this cycle still redirects the PC: pc_we=1, fd_flush=1.
  4. d_branch_taken=1: pc_we=1, fd_flush=1. One-cycle penalty.
  5. d_halt=1: pc_we=0, fd_flush=1. Next state DRAIN, counter=0. HLT itself advances to D/X.
- d_halt and d_branch_taken are never both 1; if they are, branch wins.
- A hazard suppresses branch and halt actions for that cycle. The instruction re-presents in D next cycle.
- MEM_WAIT:
  - All enables are 0 and flushes are 0.
  - mem_fill_done=1: next state RUN. Enables return to 1 the following cycle.
  - If mem_fill_done and mem_miss are both 1, the controller stays in MEM_WAIT (back-to-back miss).
  - if_miss and d_branch_taken are ignored in this state.
- DRAIN:
  - pc_we=0, fd_flush=1, dx_flush=1. xm_en and mw_en stay 1.
  - Counter increments each cycle. When counter==DRAIN_CYCLES-1, next state HALTED.
  - mem_miss=1: all enables 0 and counter holds. The controller stays frozen in DRAIN until mem_fill_done.
- HALTED: halt_done=1, all enables 0. Only rst exits this state.
- Register index 0 never creates a hazard.

Optional Feature:
- Macro: PIPE_STALL_CNT_EN.
- When defined:
  - Adds output stall_cycles[15:0].
  - Increments on every cycle in which pc_we=0 and state is RUN or MEM_WAIT.
  - Saturates at 16'hFFFF and resets to 0.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state enum typedef ctrl_state_t
  - REG_AW and DRAIN_CYCLES default constants
  - a struct pipe_ctl_t bundling the seven control outputs
- One sub-module, hazard_detect: purely combinational load-use compare producing the stall bit. The FSM stays in pipe_hazard_ctrl.

Test Plan:
- Load-use: x_memread=1, x_regwrite=1, x_rd=3, d_rs=3, d_uses_rs=1 -> one cycle of pc_we=0, fd_en=0, dx_flush=1, then all enables 1. Repeat with x_rd=0 -> no stall.
- Branch: d_branch_taken=1 for one cycle -> pc_we=1, fd_flush=1 that cycle only. Same cycle with if_miss=1 -> pc_we=1, fd_flush=1.
- D-cache miss: mem_miss=1 for 1 cycle, mem_fill_done after 5 cycles -> all enables 0 for 6 cycles, RUN on the next. mem_miss coincident with a load-use hazard -> freeze wins.
- HLT: d_halt=1 -> 3 DRAIN cycles with pc_we=0, fd_flush=1, dx_flush=1, then halt_done=1 held. mem_miss injected during the 2nd DRAIN cycle -> halt_done delayed by the miss length.
- Reset mid-MEM_WAIT and in HALTED -> outputs 0 immediately (asynchronous). After release, RUN with all enables 1 and halt_done=0.
- With PIPE_STALL_CNT_EN defined: a 4-cycle if_miss plus a 1-cycle load-use -> stall_cycles=5.
